// File: rtl/alu_op_sequencer_if.sv
// Sequencer <-> datapath bundle: run control, fetch handshake, IR and every control strobe.
interface alu_op_sequencer_if;
    localparam int unsigned IR_W  = 32;
    localparam int unsigned REG_W = 4;
    localparam int unsigned ALU_W = 3;

    logic             run;
    logic             mem_ready;
    logic [IR_W-1:0]  IR;

    logic             PCout;
    logic             Zlowout;
    logic             Zhighout;
    logic             MDRout;
    logic             MARin;
    logic             Zin;
    logic             PCin;
    logic             MDRin;
    logic             IRin;
    logic             Yin;
    logic             LOin;
    logic             HIin;
    logic             IncPC;
    logic             Read;
    logic             Rout_en;
    logic [REG_W-1:0] Rout_sel;
    logic             Rin_en;
    logic [REG_W-1:0] Rin_sel;
    logic [ALU_W-1:0] alu_op;
    logic             busy;
    logic             done;
    logic             illegal;

    // Sequencer side
    modport master (
        input  run, mem_ready, IR,
        output PCout, Zlowout, Zhighout, MDRout,
        output MARin, Zin, PCin, MDRin, IRin, Yin, LOin, HIin, IncPC, Read,
        output Rout_en, Rout_sel, Rin_en, Rin_sel, alu_op,
        output busy, done, illegal
    );

    // Datapath / run-control side
    modport slave (
        output run, mem_ready, IR,
        input  PCout, Zlowout, Zhighout, MDRout,
        input  MARin, Zin, PCin, MDRin, IRin, Yin, LOin, HIin, IncPC, Read,
        input  Rout_en, Rout_sel, Rin_en, Rin_sel, alu_op,
        input  busy, done, illegal
    );
endinterface

// File: rtl/alu_op_sequencer.sv
// Fetch/decode/execute control unit for register-register ALU, MUL and DIV instructions.
// Optional single-step mode: define ALU_SEQ_STEP_EN to add the step input.
module alu_op_sequencer #(
    parameter int unsigned DIV_CYCLES = 1
) (
    input  logic Clock,
    input  logic clear,
`ifdef ALU_SEQ_STEP_EN
    input  logic step,
`endif
    alu_op_sequencer_if.master seq
);
    localparam int unsigned CNT_W = 6;
    localparam int unsigned OP_W  = 5;
    localparam int unsigned REG_W = 4;
    localparam int unsigned ALU_W = 3;

    localparam logic [OP_W-1:0] OP_ADD = 5'h03;
    localparam logic [OP_W-1:0] OP_SUB = 5'h04;
    localparam logic [OP_W-1:0] OP_AND = 5'h05;
    localparam logic [OP_W-1:0] OP_OR  = 5'h06;
    localparam logic [OP_W-1:0] OP_MUL = 5'h02;
    localparam logic [OP_W-1:0] OP_DIV = 5'h07;

    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;

    logic [OP_W-1:0]    op;
    logic [REG_W-1:0]   ra, rb, rc;
    logic               is_alu, is_muldiv, is_div;
    logic [ALU_W-1:0]   alu_sel;
    logic               leave_idle, leave_t4;
    state_t             end_state;
    logic               unused_ir;

    assign op        = seq.IR[31:27];
    assign ra        = seq.IR[26:23];
    assign rb        = seq.IR[22:19];
    assign rc        = seq.IR[18:15];
    assign unused_ir = ^seq.IR[14:0];

    assign is_alu    = (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR);
    assign is_div    = (op == OP_DIV);
    assign is_muldiv = (op == OP_MUL) || is_div;
    assign leave_t4  = !is_div || (cnt == DIV_LAST);

`ifdef ALU_SEQ_STEP_EN
    assign leave_idle = seq.run && step;
    assign end_state  = S_IDLE;
`else
    assign leave_idle = seq.run;
    assign end_state  = seq.run ? S_T0 : S_IDLE;
`endif

    // ALU function code for the execute phase
    always_comb begin
        alu_sel = 3'd0;
        case (op)
            OP_ADD:  alu_sel = 3'd1;
            OP_SUB:  alu_sel = 3'd2;
            OP_AND:  alu_sel = 3'd3;
            OP_OR:   alu_sel = 3'd4;
            OP_MUL:  alu_sel = 3'd5;
            OP_DIV:  alu_sel = 3'd6;
            default: alu_sel = 3'd0;
        endcase
    end

    // State and T4 hold counter; clear wins over everything
    always_ff @(posedge Clock) begin
        if (clear) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                S_IDLE: if (leave_idle) state <= S_T0;
                S_T0:   state <= S_T1;
                S_T1:   if (seq.mem_ready) state <= S_T2;
                S_T2:   state <= S_T3;
                S_T3:   state <= (is_alu || is_muldiv) ? S_T4 : end_state;
                S_T4: begin
                    if (leave_t4) begin
                        cnt   <= '0;
                        state <= S_T5;
                    end else begin
                        cnt   <= cnt + CNT_W'(1);
                    end
                end
                S_T5:   state <= is_alu ? end_state : S_T6;
                S_T6:   state <= end_state;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Strobe decode from state and IR; only the T1 exit looks at mem_ready
    always_comb begin
        seq.PCout    = 1'b0;
        seq.Zlowout  = 1'b0;
        seq.Zhighout = 1'b0;
        seq.MDRout   = 1'b0;
        seq.MARin    = 1'b0;
        seq.Zin      = 1'b0;
        seq.PCin     = 1'b0;
        seq.MDRin    = 1'b0;
        seq.IRin     = 1'b0;
        seq.Yin      = 1'b0;
        seq.LOin     = 1'b0;
        seq.HIin     = 1'b0;
        seq.IncPC    = 1'b0;
        seq.Read     = 1'b0;
        seq.Rout_en  = 1'b0;
        seq.Rout_sel = '0;
        seq.Rin_en   = 1'b0;
        seq.Rin_sel  = '0;
        seq.alu_op   = '0;
        seq.done     = 1'b0;
        seq.illegal  = 1'b0;
        seq.busy     = (state != S_IDLE);
        case (state)
            S_T0: begin
                seq.PCout = 1'b1;
                seq.MARin = 1'b1;
                seq.IncPC = 1'b1;
                seq.Zin   = 1'b1;
            end
            S_T1: begin
                seq.Read    = 1'b1;
                seq.MDRin   = 1'b1;
                seq.Zlowout = seq.mem_ready;
                seq.PCin    = seq.mem_ready;
            end
            S_T2: begin
                seq.MDRout = 1'b1;
                seq.IRin   = 1'b1;
            end
            S_T3: begin
                if (is_alu || is_muldiv) begin
                    seq.Rout_en  = 1'b1;
                    seq.Rout_sel = is_alu ? rb : ra;
                    seq.Yin      = 1'b1;
                end else begin
                    seq.illegal  = 1'b1;
                end
            end
            S_T4: begin
                seq.Zin      = 1'b1;
                seq.alu_op   = alu_sel;
                seq.Rout_en  = 1'b1;
                seq.Rout_sel = is_alu ? rc : rb;
            end
            S_T5: begin
                seq.Zlowout = 1'b1;
                if (is_alu) begin
                    seq.Rin_en  = 1'b1;
                    seq.Rin_sel = ra;
                    seq.done    = 1'b1;
                end else begin
                    seq.LOin    = 1'b1;
                end
            end
            S_T6: begin
                seq.Zhighout = 1'b1;
                seq.HIin     = 1'b1;
                seq.done     = 1'b1;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench: per-cycle strobe scoreboard plus a small datapath model for LO/HI/R/PC results.
module tb_alu_op_sequencer;
    logic Clock;
    logic clear;
`ifdef ALU_SEQ_STEP_EN
    logic step;
`endif

    alu_op_sequencer_if bus_if ();

    alu_op_sequencer #(.DIV_CYCLES(4)) dut (
        .Clock (Clock),
        .clear (clear),
`ifdef ALU_SEQ_STEP_EN
        .step  (step),
`endif
        .seq   (bus_if)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    typedef struct packed {
        logic pcout, zlowout, zhighout, mdrout, marin, zin, pcin, mdrin;
        logic irin, yin, loin, hiin, incpc, read, rout_en;
        logic [3:0] rout_sel;
        logic rin_en;
        logic [3:0] rin_sel;
        logic [2:0] alu_op;
        logic busy, done, illegal;
    } ctl_t;

    typedef struct packed {
        ctl_t        exp;
        logic        mr, run, clr, stp, pk_en;
        logic [3:0]  pk_idx;
        logic [31:0] pk_val;
    } ent_t;

    ent_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    // Datapath model driven by the DUT strobes
    logic [31:0] r [0:15];
    logic [31:0] mem [0:15];
    logic [31:0] pc = 32'd0, mar = 32'd0, mdr = 32'd0, ir = 32'd0, y = 32'd0, lo = 32'd0, hi = 32'd0;
    logic [63:0] z = 64'd0;
    logic [31:0] bus;
    logic        pk_en = 1'b0;
    logic [3:0]  pk_idx = 4'd0;
    logic [31:0] pk_val = 32'd0;

    assign bus_if.IR = ir;

    always_comb begin
        bus = 32'd0;
        if (bus_if.PCout)         bus = pc;
        else if (bus_if.Zlowout)  bus = z[31:0];
        else if (bus_if.Zhighout) bus = z[63:32];
        else if (bus_if.MDRout)   bus = mdr;
        else if (bus_if.Rout_en)  bus = r[bus_if.Rout_sel];
    end

    always @(posedge Clock) begin
        if (bus_if.MARin) mar <= bus;
        if (bus_if.Yin)   y   <= bus;
        if (bus_if.Zin) begin
            case (bus_if.alu_op)
                3'd1: z <= {32'd0, y + bus};
                3'd2: z <= {32'd0, y - bus};
                3'd3: z <= {32'd0, y & bus};
                3'd4: z <= {32'd0, y | bus};
                3'd5: z <= 64'(y) * 64'(bus);
                3'd6: z <= (bus != 32'd0) ? {y % bus, y / bus} : 64'd0;
                default: if (bus_if.IncPC) z <= {32'd0, bus + 32'd1};
            endcase
        end
        if (bus_if.PCin) pc <= bus;
        if (bus_if.Read && bus_if.MDRin) mdr <= mem[mar[3:0]];
        if (bus_if.IRin) ir <= bus;
        if (bus_if.LOin) lo <= bus;
        if (bus_if.HIin) hi <= bus;
        if (bus_if.Rin_en) r[bus_if.Rin_sel] <= bus;
        if (pk_en) r[pk_idx] <= pk_val;
    end

    function automatic ctl_t sample();
        ctl_t c;
        c.pcout    = bus_if.PCout;    c.zlowout = bus_if.Zlowout; c.zhighout = bus_if.Zhighout;
        c.mdrout   = bus_if.MDRout;   c.marin   = bus_if.MARin;   c.zin      = bus_if.Zin;
        c.pcin     = bus_if.PCin;     c.mdrin   = bus_if.MDRin;   c.irin     = bus_if.IRin;
        c.yin      = bus_if.Yin;      c.loin    = bus_if.LOin;    c.hiin     = bus_if.HIin;
        c.incpc    = bus_if.IncPC;    c.read    = bus_if.Read;    c.rout_en  = bus_if.Rout_en;
        c.rout_sel = bus_if.Rout_sel; c.rin_en  = bus_if.Rin_en;  c.rin_sel  = bus_if.Rin_sel;
        c.alu_op   = bus_if.alu_op;   c.busy    = bus_if.busy;    c.done     = bus_if.done;
        c.illegal  = bus_if.illegal;
        return c;
    endfunction

    task automatic push(input ctl_t c, input logic mr, input logic rn, input logic cl, input logic st);
        ent_t e;
        e = '0;
        e.exp = c; e.mr = mr; e.run = rn; e.clr = cl; e.stp = st;
        q.push_back(e);
    endtask

    task automatic poke_last(input logic [3:0] idx, input logic [31:0] v);
        ent_t e;
        e = q.pop_back();
        e.pk_en = 1'b1; e.pk_idx = idx; e.pk_val = v;
        q.push_back(e);
    endtask

    task automatic push_idle(input logic rn, input logic cl, input logic st);
        ctl_t c;
        c = '0;
        push(c, 1'b1, rn, cl, st);
    endtask

    task automatic push_gap();
`ifdef ALU_SEQ_STEP_EN
        push_idle(1'b1, 1'b0, 1'b1);
`endif
    endtask

    task automatic push_fetch(input int waits);
        ctl_t c;
        c = '0; c.busy = 1; c.pcout = 1; c.marin = 1; c.incpc = 1; c.zin = 1;
        push(c, 1'b1, 1'b1, 1'b0, 1'b0);
        c = '0; c.busy = 1; c.read = 1; c.mdrin = 1;
        for (int i = 0; i < waits; i++) push(c, 1'b0, 1'b1, 1'b0, 1'b0);
        c.zlowout = 1; c.pcin = 1;
        push(c, 1'b1, 1'b1, 1'b0, 1'b0);
        c = '0; c.busy = 1; c.mdrout = 1; c.irin = 1;
        push(c, 1'b1, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic push_alu(input logic [2:0] op, input logic [3:0] ra, input logic [3:0] rb,
                            input logic [3:0] rc, input logic rn);
        ctl_t c;
        c = '0; c.busy = 1; c.rout_en = 1; c.rout_sel = rb; c.yin = 1;
        push(c, 1'b1, rn, 1'b0, 1'b0);
        c = '0; c.busy = 1; c.rout_en = 1; c.rout_sel = rc; c.zin = 1; c.alu_op = op;
        push(c, 1'b1, rn, 1'b0, 1'b0);
        c = '0; c.busy = 1; c.zlowout = 1; c.rin_en = 1; c.rin_sel = ra; c.done = 1;
        push(c, 1'b1, rn, 1'b0, 1'b0);
    endtask

    task automatic push_muldiv(input logic div, input logic [3:0] ra, input logic [3:0] rb,
                               input int n4, input logic rn);
        ctl_t c;
        c = '0; c.busy = 1; c.rout_en = 1; c.rout_sel = ra; c.yin = 1;
        push(c, 1'b1, rn, 1'b0, 1'b0);
        c = '0; c.busy = 1; c.rout_en = 1; c.rout_sel = rb; c.zin = 1;
        c.alu_op = div ? 3'd6 : 3'd5;
        for (int i = 0; i < n4; i++) push(c, 1'b1, rn, 1'b0, 1'b0);
        c = '0; c.busy = 1; c.zlowout = 1; c.loin = 1;
        push(c, 1'b1, rn, 1'b0, 1'b0);
        c = '0; c.busy = 1; c.zhighout = 1; c.hiin = 1; c.done = 1;
        push(c, 1'b1, rn, 1'b0, 1'b0);
    endtask

    task automatic push_illegal(input logic rn);
        ctl_t c;
        c = '0; c.busy = 1; c.illegal = 1;
        push(c, 1'b1, rn, 1'b0, 1'b0);
    endtask

    // Drive each entry's inputs after the rising edge, compare strobes on the falling edge
    task automatic run_q();
        ent_t e;
        ctl_t obs;
        while (q.size() > 0) begin
            e = q.pop_front();
            @(posedge Clock); #1;
            bus_if.mem_ready = e.mr;
            bus_if.run       = e.run;
            clear            = e.clr;
`ifdef ALU_SEQ_STEP_EN
            step             = e.stp;
`endif
            pk_en  = e.pk_en;
            pk_idx = e.pk_idx;
            pk_val = e.pk_val;
            @(negedge Clock);
            obs = sample();
            cyc++;
            total++;
            assert (obs === e.exp) else begin
                bad++;
                $error("FAIL trace cyc=%0d obs=%h exp=%h", cyc, obs, e.exp);
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    initial begin
        ctl_t c;
        clear = 1'b1;
        bus_if.run = 1'b0;
        bus_if.mem_ready = 1'b1;
`ifdef ALU_SEQ_STEP_EN
        step = 1'b0;
`endif
        for (int i = 0; i < 16; i++) begin
            mem[i] = 32'hF800_0000;
            r[i]   = 32'd0;
        end
        mem[0] = 32'h1118_0000;   // MUL r2,r3
        mem[1] = 32'h1918_8000;   // ADD r2,r3,r1
        mem[2] = 32'h3918_0000;   // DIV r2,r3
        mem[3] = 32'hF800_0000;   // unknown opcode
        mem[4] = 32'h3898_0000;   // DIV r1,r3

        // Reset, then clear together with run must still hold IDLE
        push_idle(1'b0, 1'b1, 1'b0); poke_last(4'd1, 32'd9);
        push_idle(1'b1, 1'b1, 1'b0); poke_last(4'd2, 32'h87);
        push_idle(1'b1, 1'b0, 1'b1); poke_last(4'd3, 32'd3);

        // MUL, run drops during execute
        push_fetch(0);
        push_muldiv(1'b0, 4'd2, 4'd3, 1, 1'b0);
        push_idle(1'b0, 1'b0, 1'b0); poke_last(4'd3, 32'd5);
        push_idle(1'b0, 1'b0, 1'b0);
        run_q();
        chk("mul_lo", lo, 32'h195);
        chk("mul_hi", hi, 32'h0);
        chk("mul_pc", pc, 32'd1);

        // ADD with a 3-cycle memory wait
        push_idle(1'b1, 1'b0, 1'b1);
        push_fetch(3);
        push_alu(3'd1, 4'd2, 4'd3, 4'd1, 1'b0);
        push_idle(1'b0, 1'b0, 1'b0);
        run_q();
        chk("add_r2", r[2], 32'hE);
        chk("add_pc", pc, 32'd2);

        // DIV, unknown opcode and a second DIV cleared mid-hold, all back-to-back
        push_idle(1'b0, 1'b0, 1'b0); poke_last(4'd2, 32'h64);
        push_idle(1'b0, 1'b0, 1'b0); poke_last(4'd3, 32'd7);
        push_idle(1'b1, 1'b0, 1'b1);
        push_fetch(0);
        push_muldiv(1'b1, 4'd2, 4'd3, 4, 1'b1);
        push_gap();
        push_fetch(0);
        push_illegal(1'b1);
        push_gap();
        push_fetch(0);
        c = '0; c.busy = 1; c.rout_en = 1; c.rout_sel = 4'd1; c.yin = 1;
        push(c, 1'b1, 1'b1, 1'b0, 1'b0);
        c = '0; c.busy = 1; c.rout_en = 1; c.rout_sel = 4'd3; c.zin = 1; c.alu_op = 3'd6;
        push(c, 1'b1, 1'b1, 1'b0, 1'b0);
        push(c, 1'b1, 1'b0, 1'b1, 1'b0);
        push_idle(1'b0, 1'b0, 1'b0);
        push_idle(1'b0, 1'b0, 1'b0);
        run_q();
        chk("div_lo", lo, 32'hE);
        chk("div_hi", hi, 32'h2);
        chk("div_pc", pc, 32'd5);

`ifdef ALU_SEQ_STEP_EN
        // Step mode: run alone never leaves IDLE after an instruction
        push_idle(1'b1, 1'b0, 1'b1);
        push_fetch(0);
        push_illegal(1'b1);
        push_idle(1'b1, 1'b0, 1'b0);
        push_idle(1'b1, 1'b0, 1'b0);
`else
        // Unknown opcode followed directly by the next fetch
        push_idle(1'b1, 1'b0, 1'b0);
        push_fetch(0);
        push_illegal(1'b1);
        push_fetch(0);
        push_illegal(1'b0);
        push_idle(1'b0, 1'b0, 1'b0);
`endif
        run_q();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
